// File: rtl/pwm_duty_slew.sv
// Duty-cycle holder for the PWM compare stage.
// Ramps toward a loaded target in bounded steps, updating only at PWM period boundaries.
module pwm_duty_slew #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [WIDTH-1:0]  target_in,
  input  logic [STEP_W-1:0] step_in,
  input  logic [DIV_W-1:0]  div_in,
  input  logic              load,
  input  logic              period_start,
  output logic [WIDTH-1:0]  duty_out,
  output logic              duty_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  duty, duty_nx;
  logic [WIDTH-1:0]  target, target_nx;
  logic [STEP_W-1:0] step, step_nx;
  logic [DIV_W-1:0]  div, div_nx;
  logic [DIV_W-1:0]  tick, tick_nx;
  logic              valid_r, valid_nx;
  logic              done_r, done_nx;

  logic [WIDTH:0]    step_ext;
  logic [WIDTH:0]    sum_up;
  logic [WIDTH-1:0]  diff_dn;
  logic [WIDTH-1:0]  stepped;
  logic              qual;

  always_comb begin
    state_nx  = state;
    duty_nx   = duty;
    target_nx = target;
    step_nx   = step;
    div_nx    = div;
    tick_nx   = tick;
    valid_nx  = 1'b0;
    done_nx   = 1'b0;

    // One extra bit on the up path so duty+step saturates at target instead of wrapping.
    step_ext = (WIDTH+1)'(step);
    sum_up   = {1'b0, duty} + step_ext;
    diff_dn  = duty - target;
    if (duty < target) begin
      stepped = (sum_up >= {1'b0, target}) ? target : sum_up[WIDTH-1:0];
    end else begin
      stepped = ({1'b0, diff_dn} <= step_ext) ? target : (duty - step_ext[WIDTH-1:0]);
    end

    qual = period_start & ena & (state == RAMP) & ~load;

    if (load) begin
      target_nx = target_in;
      step_nx   = (step_in == '0) ? STEP_W'(1) : step_in;
      div_nx    = div_in;
      tick_nx   = '0;
      if (target_in == duty) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end else begin
        state_nx = RAMP;
      end
    end else if (qual) begin
      if (tick != div) begin
        tick_nx = tick + DIV_W'(1);
      end else begin
        tick_nx  = '0;
        duty_nx  = stepped;
        valid_nx = 1'b1;
        if (stepped == target) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      duty    <= '0;
      target  <= '0;
      step    <= STEP_W'(1);
      div     <= '0;
      tick    <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nx;
      duty    <= duty_nx;
      target  <= target_nx;
      step    <= step_nx;
      div     <= div_nx;
      tick    <= tick_nx;
      valid_r <= valid_nx;
      done_r  <= done_nx;
    end
  end

  assign duty_out   = duty;
  assign duty_valid = valid_r;
  assign done       = done_r;
  assign busy       = (state == RAMP);

endmodule

// File: tb/tb_pwm_duty_slew.sv
// Randomized plus directed bench for pwm_duty_slew with a behavioural model and event scoreboard.
module tb_pwm_duty_slew;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] target_in = '0;
  logic [3:0] step_in = '0;
  logic [7:0] div_in = '0;
  logic       load = 1'b0;
  logic       period_start = 1'b0;
  logic [7:0] duty_out;
  logic       duty_valid;
  logic       busy;
  logic       done;

  pwm_duty_slew #(.WIDTH(8), .STEP_W(4), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .target_in(target_in), .step_in(step_in),
    .div_in(div_in), .load(load), .period_start(period_start),
    .duty_out(duty_out), .duty_valid(duty_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    bit valid;
    bit done;
    bit busy;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_pass = 0;

  // Reference model state: what the outputs should be after the most recent edge.
  int m_duty = 0, m_target = 0, m_step = 1, m_div = 0, m_cnt = 0;
  bit m_ramp = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Predict the effect of the upcoming clock edge from the inputs now being driven.
  task automatic model_edge();
    ev_t e;
    if (rst) begin
      m_duty = 0; m_target = 0; m_step = 1; m_div = 0; m_cnt = 0; m_ramp = 0;
    end else if (load) begin
      m_target = int'(target_in);
      m_step   = (step_in == 0) ? 1 : int'(step_in);
      m_div    = int'(div_in);
      m_cnt    = 0;
      if (m_target == m_duty) begin
        m_ramp = 0;
        e.duty = m_duty; e.valid = 0; e.done = 1; e.busy = 0;
        sb.push_back(e);
      end else begin
        m_ramp = 1;
      end
    end else if (period_start && ena && m_ramp) begin
      if (m_cnt < m_div) begin
        m_cnt++;
      end else begin
        m_cnt = 0;
        if (m_duty < m_target)
          m_duty = (m_duty + m_step > m_target) ? m_target : m_duty + m_step;
        else
          m_duty = (m_duty - m_target <= m_step) ? m_target : m_duty - m_step;
        if (m_duty == m_target) m_ramp = 0;
        e.duty = m_duty; e.valid = 1; e.done = (m_duty == m_target); e.busy = m_ramp;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drive(input bit r, input bit ld, input bit ps);
    rst = r; load = ld; period_start = ps;
    model_edge();
    @(posedge clk);
    #1;
    chk("duty_out", int'(duty_out), m_duty);
    chk("busy", int'(busy), int'(m_ramp));
  endtask

  task automatic pulse();
    drive(0, 0, 1);
    drive(0, 0, 0);
  endtask

  task automatic do_load(input int t, input int s, input int d);
    target_in = 8'(t); step_in = 4'(s); div_in = 8'(d);
    drive(0, 1, 0);
  endtask

  task automatic run_to(input int t);
    do_load(t, 15, 0);
    for (int i = 0; i < 40; i++) begin
      if (!m_ramp) break;
      pulse();
    end
  endtask

  // Monitor: every output event from the DUT consumes one expected entry.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (duty_valid || done) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("ev_duty", int'(duty_out), e.duty);
          chk("ev_valid", int'(duty_valid), int'(e.valid));
          chk("ev_done", int'(done), int'(e.done));
          chk("ev_busy", int'(busy), int'(e.busy));
        end
      end
    end
  end

  initial begin
    // Reset then idle pulses
    drive(1, 0, 0);
    drive(1, 0, 0);
    for (int i = 0; i < 5; i++) pulse();

    // Ramp up 3,6,9,10
    do_load(10, 3, 0);
    for (int i = 0; i < 5; i++) pulse();

    // Ramp down with divider: 6, then 2
    do_load(2, 4, 1);
    for (int i = 0; i < 5; i++) pulse();

    // Saturation at top
    run_to(250);
    do_load(255, 15, 0);
    pulse();
    pulse();

    // Saturation at bottom
    run_to(5);
    do_load(0, 15, 0);
    pulse();

    // Equal target
    do_load(0, 7, 0);
    drive(0, 0, 0);

    // Load coincident with period_start, then ramp to 6 and retarget to 20
    target_in = 8'd6; step_in = 4'd3; div_in = 8'd0;
    drive(0, 1, 1);
    pulse();
    pulse();
    do_load(20, 3, 0);
    pulse();
    pulse();

    // Enable low freezes ramping
    ena = 1'b0;
    for (int i = 0; i < 3; i++) pulse();
    ena = 1'b1;
    pulse();

    // Reset mid-ramp
    drive(1, 0, 0);
    drive(0, 0, 1);
    pulse();

    // Step input of zero behaves as one
    do_load(3, 0, 0);
    for (int i = 0; i < 4; i++) pulse();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, ld, ps;
      ena = ($urandom_range(7) != 0);
      r   = ($urandom_range(199) == 0);
      ld  = ($urandom_range(11) == 0);
      ps  = ($urandom_range(2) == 0);
      if (ld) begin
        case ($urandom_range(3))
          0: target_in = 8'd0;
          1: target_in = 8'd255;
          default: target_in = 8'($urandom_range(255));
        endcase
        step_in = 4'($urandom_range(15));
        div_in  = 8'($urandom_range(2));
      end
      drive(r, ld, ps);
    end

    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("queue_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_duty_slew.md
Name: pwm_duty_slew

Overview:
- Upstream feeder for the PWM core: holds the duty-cycle value the PWM counter compares against.
- Ramps that value toward a loaded target in bounded steps, giving soft-start and slew-limited duty changes.
- Duty updates only at PWM period boundaries, signalled by the core's period_start pulse, so no partial period ever sees a torn value.
- Sits between the ui_in-driven configuration path and the PWM compare stage.

Parameters:
- WIDTH, 8: duty / target width in bits.
- STEP_W, 4: width of the step-size input.
- DIV_W, 8: width of the step-interval divider.

Ports:
- clk, input, 1: single design clock.
- rst, input, 1: synchronous reset, active-high.
- ena, input, 1: enable; low freezes ramping.
- target_in, input, WIDTH: requested final duty.
- step_in, input, STEP_W: duty increment/decrement per step; 0 is treated as 1.
- div_in, input, DIV_W: a step occurs every (div_in+1) qualifying period_start pulses.
- load, input, 1: one-cycle strobe; captures target_in, step_in and div_in.
- period_start, input, 1: one-cycle pulse from the PWM core at each period start.
- duty_out, output, WIDTH: current duty presented to the PWM compare.
- duty_valid, output, 1: one-cycle pulse in the cycle duty_out takes a new value.
- busy, output, 1: high while ramping.
- done, output, 1: one-cycle pulse when duty_out reaches target.

Behaviour:
- Reset (rst=1 at clk edge) sets:
  - duty_out=0, duty_valid=0, busy=0, done=0.
  - Internal target=0, step=1, div=0, tick counter=0.
  - State IDLE.
- Reset overrides everything, including mid-ramp; duty_out returns to 0.
- States:
  - IDLE: busy=0.
  - RAMP: busy=1.
- load sampled high, in any state:
  - Latch target_in, max(step_in,1) and div_in; clear the tick counter.
  - Next cycle, if latched target == duty_out: stay/return to IDLE, busy=0, done=1 for one cycle, duty_valid stays 0.
  - Otherwise: state RAMP, busy=1.
  - load in RAMP retargets from the current duty_out; duty_out does not jump.
- Qualifying period: period_start=1 AND ena=1 AND state RAMP AND load=0.
- load and period_start in the same cycle: load wins; no step and no tick count that cycle.
- On a qualifying period with tick counter != div:
  - tick counter increments.
  - Counter width DIV_W; it never exceeds div, because it is cleared whenever it reaches div.
- On a qualifying period with tick counter == div:
  - Clear the tick counter and step duty_out on the next clock edge (latency 1 cycle from period_start).
  - Up (duty<target): duty = min(duty+step, target), computed WIDTH+1 bits wide. Never wraps past 2^WIDTH-1.
  - Down (duty>target): duty = (duty-target <= step) ? target : duty-step. Never underflows below 0.
  - duty_valid=1 in the same cycle the new duty_out appears.
  - If the new duty == target: state IDLE, busy=0, done=1 in that same cycle.
- ena=0:
  - Tick counter and duty_out hold.
  - period_start is ignored.
  - load is still accepted.
- period_start in IDLE has no effect; duty_out holds indefinitely.
- done and duty_valid are never high for more than one consecutive cycle per event.
- Outputs are all registered; no combinational path from any input to any output.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then 5 period_start pulses.
  - Required: duty_out=0, busy=0, done=0, duty_valid=0 throughout.
- Ramp up:
  - Stimulus: load target=10, step=3, div=0; 4 period_start pulses.
  - Required: duty_out steps 3, 6, 9, 10, each one cycle after its pulse with duty_valid.
  - Required: done pulses with the 10; busy then drops.
- Ramp down with divider:
  - Stimulus: from duty 10, load target=2, step=4, div=1.
  - Required: duty_out changes only on every 2nd pulse: 6, then 2; done on 2.
- Saturation:
  - Stimulus: from duty 250, load target=255, step=15, div=0.
  - Required: one pulse gives duty 255 (no wrap to 9), done=1.
  - Stimulus: separately, from 5, load target=0, step=15.
  - Required: duty 0.
- Equal target and collisions:
  - Stimulus: load target equal to current duty.
    - Required: done next cycle, no duty_valid, busy stays 0.
  - Stimulus: load coincident with period_start.
    - Required: no step that cycle.
  - Stimulus: retarget mid-ramp from 6 to 20.
    - Required: continues 9, 12, ... from 6.
- Enable and reset mid-ramp:
  - Stimulus: ena=0 during 3 pulses.
    - Required: duty_out frozen; resumes correctly after ena=1.
  - Stimulus: rst=1 mid-ramp.
    - Required: duty_out=0, busy=0 next cycle.
